// File: rtl/i2c_wr_engine.sv
// i2c_wr_engine
// Pops 16-bit command words from a sync_fifo and sends each one as a single
// I2C write: START, {SLAVE_ADDR,W}, word[15:8], word[7:0], STOP.
// SCL and SDA are open-drain enables (1 = release, 0 = pull low).
//
// Ports:
//   clk        in   system clock
//   arst       in   asynchronous reset, active-high
//   fifo_data  in   FIFO head word, valid whenever fifo_empty = 0
//   fifo_empty in   FIFO empty flag
//   fifo_pop   out  registered one-clk pop strobe
//   sda_i      in   sampled SDA line, used to read the slave ACK
//   scl_o      out  SCL enable (1 = release)
//   sda_o      out  SDA enable (1 = release)
//   busy       out  high from word capture until the end of STOP
//   nack       out  one-clk pulse when an ACK slot reads 1
module i2c_wr_engine #(
    parameter int         CLK_FREQ   = 100_000_000,
    parameter int         I2C_FREQ   = 100_000,
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    input  logic                  sda_i,
    output logic                  scl_o,
    output logic                  sda_o,
    output logic                  busy,
    output logic                  nack
);

    // Quarter-bit divider; CLK_FREQ/(4*I2C_FREQ) must be at least 2.
    localparam int               DIV       = CLK_FREQ / (4 * I2C_FREQ);
    localparam int               DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [7:0]       ADDR_BYTE = {SLAVE_ADDR, 1'b0};

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_START, S_ADDR, S_ACK_A,
        S_REG, S_ACK_R, S_DATA, S_ACK_D, S_STOP
    } state_t;

    state_t                r_state;
    logic [DIV_W-1:0]      r_div;
    logic [1:0]            r_q;
    logic [2:0]            r_bit;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  r_scl;
    logic                  r_sda;
    logic                  r_pop;
    logic                  r_busy;
    logic                  r_nack;
    logic                  r_nack_seen;

    logic                  w_tick;
    logic                  w_ack_slot;
    logic [7:0]            w_byte;
    logic                  w_bit;
    logic                  w_scl;
    logic                  w_sda;

    assign w_tick     = (r_div == DIV_LAST) && (r_state != S_IDLE) && (r_state != S_LOAD);
    assign w_ack_slot = (r_state == S_ACK_A) || (r_state == S_ACK_R) || (r_state == S_ACK_D);

    always_comb begin
        w_byte = ADDR_BYTE;
        case (r_state)
            S_REG:   w_byte = r_word[15:8];
            S_DATA:  w_byte = r_word[7:0];
            default: w_byte = ADDR_BYTE;
        endcase
    end

    // r_bit counts 0..7 while bits go out MSB first, so ~r_bit == 7 - r_bit.
    assign w_bit = w_byte[~r_bit];

    // Line levels for the current state/quarter; registered below, so the
    // pins trail the FSM by one clk.
    always_comb begin
        w_scl = 1'b1;
        w_sda = 1'b1;
        case (r_state)
            S_START: begin
                w_scl = ~r_q[1];
                w_sda = (r_q == 2'd0);
            end
            S_ADDR, S_REG, S_DATA: begin
                w_scl = (r_q == 2'd1) || (r_q == 2'd2);
                w_sda = w_bit;
            end
            S_ACK_A, S_ACK_R, S_ACK_D: begin
                w_scl = (r_q == 2'd1) || (r_q == 2'd2);
                w_sda = 1'b1;
            end
            S_STOP: begin
                w_scl = (r_q != 2'd0);
                w_sda = r_q[1];
            end
            default: begin
                w_scl = 1'b1;
                w_sda = 1'b1;
            end
        endcase
    end

    // Payload word: captured with the pop, needs no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && !fifo_empty) begin
            r_word <= fifo_data;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_q         <= '0;
            r_bit       <= '0;
            r_scl       <= 1'b1;
            r_sda       <= 1'b1;
            r_pop       <= 1'b0;
            r_busy      <= 1'b0;
            r_nack      <= 1'b0;
            r_nack_seen <= 1'b0;
        end else begin
            r_scl  <= w_scl;
            r_sda  <= w_sda;
            r_pop  <= 1'b0;
            r_nack <= 1'b0;

            if (r_state == S_IDLE || r_state == S_LOAD || w_tick) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        r_pop   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                // One clk to let the FIFO retire the popped word.
                S_LOAD: begin
                    r_q         <= '0;
                    r_bit       <= '0;
                    r_nack_seen <= 1'b0;
                    r_state     <= S_START;
                end
                default: begin
                    if (w_tick) begin
                        r_q <= r_q + 2'd1;
                        // ACK is sampled at the end of the SCL-high window;
                        // the slot still finishes with SCL low before STOP so
                        // the released SDA cannot fall while SCL is high.
                        if (w_ack_slot && r_q == 2'd2 && sda_i) begin
                            r_nack      <= 1'b1;
                            r_nack_seen <= 1'b1;
                        end
                        if (r_q == 2'd3) begin
                            case (r_state)
                                S_START: r_state <= S_ADDR;
                                S_ADDR: begin
                                    r_bit <= r_bit + 3'd1;
                                    if (r_bit == 3'd7) r_state <= S_ACK_A;
                                end
                                S_REG: begin
                                    r_bit <= r_bit + 3'd1;
                                    if (r_bit == 3'd7) r_state <= S_ACK_R;
                                end
                                S_DATA: begin
                                    r_bit <= r_bit + 3'd1;
                                    if (r_bit == 3'd7) r_state <= S_ACK_D;
                                end
                                S_ACK_A: r_state <= r_nack_seen ? S_STOP : S_REG;
                                S_ACK_R: r_state <= r_nack_seen ? S_STOP : S_DATA;
                                S_ACK_D: r_state <= S_STOP;
                                S_STOP: begin
                                    r_busy  <= 1'b0;
                                    r_state <= S_IDLE;
                                end
                                default: r_state <= S_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign scl_o    = r_scl;
    assign sda_o    = r_sda;
    assign fifo_pop = r_pop;
    assign busy     = r_busy;
    assign nack     = r_nack;

endmodule
